// File: rtl/jtflane_pcm_sched.sv
// ---------------------------------------------------------------------------
// jtflane_pcm_sched
//
// Shares one 8-bit SDRAM ROM slot between the four PCM sample channels
// (A-D). Each channel owns a one-byte tagged cache with its own cs/ok
// handshake. Cache misses are sent to the SDRAM slot one at a time and
// granted in round-robin order.
//
// Parameters
//   AW        channel byte-address width
//
// Ports
//   clk       system clock (24 MHz domain)
//   rst       synchronous, active-high reset
//   ch_addr   channel addresses, channel i at [i*AW +: AW]
//   ch_cs     channel read requests
//   ch_dout   channel data, channel i at [i*8 +: 8]
//   ch_ok     channel data valid for the current ch_addr
//   rom_cs    SDRAM slot request
//   rom_ch    channel being fetched (region offset added by the top level)
//   rom_addr  fetch byte address
//   rom_data  slot data
//   rom_ok    slot data valid for rom_addr
// ---------------------------------------------------------------------------
module jtflane_pcm_sched #(
    parameter int AW = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*AW-1:0]   ch_addr,
    input  logic [3:0]        ch_cs,
    output logic [31:0]       ch_dout,
    output logic [3:0]        ch_ok,
    output logic              rom_cs,
    output logic [1:0]        rom_ch,
    output logic [AW-1:0]     rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              rom_ok
);

    // GUARD exists because rom_ok from the previous address may still be
    // high in the cycle after a new request is issued.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;

    // Per-channel one-byte cache
    logic [AW-1:0]   tag   [4];
    logic [7:0]      data  [4];
    logic [3:0]      valid;

    logic [AW-1:0]   addr  [4];
    logic [3:0]      hit;
    logic [3:0]      in_flight;
    logic [3:0]      miss;

    logic [1:0]      ptr;
    logic [1:0]      grant;
    logic            any_miss;
    logic            do_grant;
    logic            do_fill;

    // Unpack the flat channel address bus and present the cached bytes.
    // ch_dout always shows the cache contents; ch_ok tells the chip whether
    // that byte belongs to the address it is asking for right now.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            addr[i]           = ch_addr[i*AW +: AW];
            ch_dout[i*8 +: 8] = data[i];
        end
    end

    // Hit/miss classification. A channel whose fetch is already in flight
    // is not a new miss, even if its address moved away from the latched
    // one; it is re-evaluated once the FSM returns to IDLE.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hit[i]       = ch_cs[i] & valid[i] & (tag[i] == addr[i]);
            in_flight[i] = rom_cs & (rom_ch == 2'(i));
            miss[i]      = ch_cs[i] & ~hit[i] & ~in_flight[i];
        end
    end

    assign ch_ok = hit;

    // Round-robin search starting at ptr and wrapping modulo 4. The first
    // channel found with a pending miss wins.
    always_comb begin
        logic [1:0] idx;
        grant    = ptr;
        any_miss = 1'b0;
        idx      = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!any_miss && miss[idx]) begin
                grant    = idx;
                any_miss = 1'b1;
            end
        end
    end

    // Next-state logic. do_grant launches a new fetch, do_fill writes the
    // returned byte into the fetched channel's cache entry. rom_ok is only
    // looked at in WAIT.
    always_comb begin
        next_state = state;
        do_grant   = 1'b0;
        do_fill    = 1'b0;
        case (state)
            IDLE: begin
                if (any_miss) begin
                    do_grant   = 1'b1;
                    next_state = GUARD;
                end
            end
            GUARD: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (rom_ok) begin
                    do_fill    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register plus the fetch request and the cache arrays.
    // rom_addr/rom_ch only change on a grant, so they stay stable for the
    // whole time rom_cs is high. A fill only touches the entry of rom_ch,
    // so hits on the other channels keep being served during a fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rom_cs   <= 1'b0;
            rom_ch   <= 2'd0;
            rom_addr <= '0;
            ptr      <= 2'd0;
            valid    <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                tag[i]  <= '0;
                data[i] <= 8'd0;
            end
        end else begin
            state <= next_state;
            if (do_grant) begin
                rom_cs   <= 1'b1;
                rom_ch   <= grant;
                rom_addr <= addr[grant];
                ptr      <= grant + 2'd1;
            end
            if (do_fill) begin
                tag[rom_ch]   <= rom_addr;
                data[rom_ch]  <= rom_data;
                valid[rom_ch] <= 1'b1;
                rom_cs        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtflane_pcm_sched.sv
// ---------------------------------------------------------------------------
// tb_jtflane_pcm_sched
//
// Self-checking bench for jtflane_pcm_sched. Every fetch the bench expects
// is queued when the request is driven; each rising edge of rom_cs pops the
// queue and compares rom_ch/rom_addr. The SDRAM slot is modelled by
// rom_byte(), so cached data can be predicted from the address alone.
// ---------------------------------------------------------------------------
module tb_jtflane_pcm_sched;

    localparam int AW = 19;

    logic              clk = 1'b0;
    logic              rst;
    logic [4*AW-1:0]   ch_addr;
    logic [3:0]        ch_cs;
    logic [31:0]       ch_dout;
    logic [3:0]        ch_ok;
    logic              rom_cs;
    logic [1:0]        rom_ch;
    logic [AW-1:0]     rom_addr;
    logic [7:0]        rom_data;
    logic              rom_ok;

    typedef struct {
        logic [1:0]    ch;
        logic [AW-1:0] addr;
    } fetch_t;

    fetch_t sb[$];
    int     checks   = 0;
    int     failures = 0;
    logic   cs_q     = 1'b0;

    jtflane_pcm_sched #(.AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_addr  (ch_addr),
        .ch_cs    (ch_cs),
        .ch_dout  (ch_dout),
        .ch_ok    (ch_ok),
        .rom_cs   (rom_cs),
        .rom_ch   (rom_ch),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_ok   (rom_ok)
    );

    // 24 MHz-ish clock; only the cycle count matters here
    always #5 clk = ~clk;

    // SDRAM content model
    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h78;
    endfunction

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // Advance one cycle and land 1 time unit after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setAddr(input int ch, input logic [AW-1:0] a);
        ch_addr[ch*AW +: AW] = a;
    endtask

    task automatic applyStimulus(input logic [3:0] cs, input int ch,
                                 input logic [AW-1:0] a);
        ch_cs = cs;
        setAddr(ch, a);
    endtask

    task automatic expectFetch(input int ch, input logic [AW-1:0] a);
        fetch_t f;
        f.ch   = 2'(ch);
        f.addr = a;
        sb.push_back(f);
    endtask

    // Wait (bounded) for rom_cs, then answer after 'delay' cycles with a
    // one-cycle rom_ok pulse carrying the modelled byte.
    task automatic serveOne(input int delay);
        int n = 0;
        while (!rom_cs && n < 20) begin
            tick();
            n++;
        end
        checkOutput("rom_cs_wait", 32'(rom_cs), 32'd1);
        if (rom_cs) begin
            repeat (delay) tick();
            rom_ok   = 1'b1;
            rom_data = rom_byte(rom_addr);
            tick();
            rom_ok   = 1'b0;
        end
    endtask

    // Fetch monitor: each new request must match the head of the queue
    always @(negedge clk) begin
        if (rom_cs && !cs_q) begin
            checkOutput("fetch_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                fetch_t f;
                f = sb.pop_front();
                checkOutput("fetch_ch",   32'(rom_ch),   32'(f.ch));
                checkOutput("fetch_addr", 32'(rom_addr), 32'(f.addr));
            end
        end
        cs_q = rom_cs;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        ch_cs    = 4'd0;
        ch_addr  = '0;
        rom_ok   = 1'b0;
        rom_data = 8'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("rst_ch_ok",    32'(ch_ok),    32'd0);
        checkOutput("rst_ch_dout",  ch_dout,       32'd0);
        checkOutput("rst_rom_cs",   32'(rom_cs),   32'd0);
        checkOutput("rst_rom_addr", 32'(rom_addr), 32'd0);

        // Single miss, rom_ok four cycles after rom_cs rises
        $display("[TB] single miss");
        applyStimulus(4'b0001, 0, 19'h00123);
        expectFetch(0, 19'h00123);
        #1 checkOutput("t1_miss_no_ok", 32'(ch_ok), 32'd0);
        tick();
        checkOutput("t1_cs_rise", 32'(rom_cs), 32'd1);
        repeat (4) tick();
        rom_ok   = 1'b1;
        rom_data = rom_byte(rom_addr);
        #1 checkOutput("t1_ok_not_yet", 32'(ch_ok[0]), 32'd0);
        tick();
        rom_ok = 1'b0;
        checkOutput("t1_ok_after", 32'(ch_ok[0]), 32'd1);
        checkOutput("t1_dout", 32'(ch_dout[7:0]), 32'h5A);
        checkOutput("t1_cs_fall", 32'(rom_cs), 32'd0);
        ch_cs = 4'b0000;
        #1 checkOutput("t1_cs_low", 32'(ch_ok), 32'd0);
        tick();
        ch_cs = 4'b0001;
        #1 checkOutput("t1_rehit", 32'(ch_ok[0]), 32'd1);
        repeat (3) tick();
        checkOutput("t1_no_refetch", 32'(rom_cs), 32'd0);

        // Lingering rom_ok must be ignored in GUARD
        $display("[TB] lingering ok");
        rom_ok = 1'b1;
        applyStimulus(4'b0001, 0, 19'h00200);
        expectFetch(0, 19'h00200);
        tick();
        checkOutput("t2_cs_rise", 32'(rom_cs), 32'd1);
        checkOutput("t2_guard_a", 32'(ch_ok[0]), 32'd0);
        tick();
        rom_data = rom_byte(19'h00200);
        checkOutput("t2_guard_b", 32'(ch_ok[0]), 32'd0);
        tick();
        rom_ok = 1'b0;
        checkOutput("t2_fill_ok", 32'(ch_ok[0]), 32'd1);
        checkOutput("t2_fill_dout", 32'(ch_dout[7:0]), 32'(rom_byte(19'h00200)));
        checkOutput("t2_cs_fall", 32'(rom_cs), 32'd0);

        // Fairness after reset: 0,1,2,3 then 0 and 3 with ptr back at 0
        $display("[TB] fairness");
        ch_cs = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ch_cs = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            setAddr(i, 19'(32'h1000 + i * 32'h100));
            expectFetch(i, 19'(32'h1000 + i * 32'h100));
        end
        for (int i = 0; i < 4; i++) serveOne(1);
        checkOutput("t3_all_ok", 32'(ch_ok), 32'hF);
        checkOutput("t3_all_dout", ch_dout,
                    {rom_byte(19'h1300), rom_byte(19'h1200),
                     rom_byte(19'h1100), rom_byte(19'h1000)});
        setAddr(0, 19'h1010);
        setAddr(3, 19'h1313);
        expectFetch(0, 19'h1010);
        expectFetch(3, 19'h1313);
        serveOne(2);
        serveOne(2);
        checkOutput("t3_pair_ok", 32'(ch_ok), 32'hF);

        // Address change during WAIT
        $display("[TB] address change mid-fetch");
        applyStimulus(4'b0010, 1, 19'h00010);
        expectFetch(1, 19'h00010);
        tick();
        checkOutput("t4_cs_rise", 32'(rom_cs), 32'd1);
        tick();
        setAddr(1, 19'h00011);
        expectFetch(1, 19'h00011);
        tick();
        rom_ok   = 1'b1;
        rom_data = rom_byte(rom_addr);
        tick();
        rom_ok = 1'b0;
        checkOutput("t4_ok_low", 32'(ch_ok[1]), 32'd0);
        checkOutput("t4_dout_old", 32'(ch_dout[15:8]), 32'(rom_byte(19'h00010)));
        checkOutput("t4_cs_fall", 32'(rom_cs), 32'd0);
        setAddr(1, 19'h00010);
        #1 checkOutput("t4_tag_old", 32'(ch_ok[1]), 32'd1);
        setAddr(1, 19'h00011);
        serveOne(2);
        checkOutput("t4_new_ok", 32'(ch_ok[1]), 32'd1);
        checkOutput("t4_new_dout", 32'(ch_dout[15:8]), 32'(rom_byte(19'h00011)));

        // Hit on channel 2 while channel 0 is fetching
        $display("[TB] hit during fetch");
        applyStimulus(4'b0100, 2, 19'h00040);
        expectFetch(2, 19'h00040);
        serveOne(1);
        ch_cs = 4'b0101;
        setAddr(0, 19'h00300);
        expectFetch(0, 19'h00300);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("t5_hit2", {23'd0, ch_ok[2], ch_dout[23:16]},
                        {23'd0, 1'b1, rom_byte(19'h00040)});
        end
        rom_ok   = 1'b1;
        rom_data = rom_byte(rom_addr);
        tick();
        rom_ok = 1'b0;
        checkOutput("t5_both_ok", 32'(ch_ok), 32'h5);
        checkOutput("t5_dout2", 32'(ch_dout[23:16]), 32'(rom_byte(19'h00040)));

        // Reset while WAITing, then a late rom_ok
        $display("[TB] reset in wait");
        applyStimulus(4'b1100, 3, 19'h00500);
        expectFetch(3, 19'h00500);
        tick();
        checkOutput("t6_cs_rise", 32'(rom_cs), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6_rst_cs", 32'(rom_cs), 32'd0);
        checkOutput("t6_rst_ok", 32'(ch_ok), 32'd0);
        ch_cs    = 4'b0000;
        rom_ok   = 1'b1;
        rom_data = 8'hEE;
        tick();
        rom_ok = 1'b0;
        checkOutput("t6_late_cs", 32'(rom_cs), 32'd0);
        ch_cs = 4'b0101;
        setAddr(0, 19'h00000);
        setAddr(2, 19'h00040);
        #1 checkOutput("t6_late_ok", 32'(ch_ok), 32'd0);
        expectFetch(0, 19'h00000);
        expectFetch(2, 19'h00040);
        serveOne(1);
        serveOne(1);
        checkOutput("t6_refill_ok", 32'(ch_ok), 32'h5);
        checkOutput("t6_refill_dout0", 32'(ch_dout[7:0]), 32'(rom_byte(19'h00000)));

        repeat (2) tick();
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
